// File: rtl/vec_issue_arbiter.sv
// ============================================================================
// Module   : vec_issue_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one vector unit among
//            reqs_p requesters; optional counters under VEC_ISSUE_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_issue_arbiter #(
    parameter  int reqs_p = 2,
    parameter  int els_p  = 8,
    parameter  int vlen_p = 8,
    parameter  int vdw_p  = 8,
    localparam int c_VAW  = $clog2(els_p),
    localparam int c_DW   = vlen_p * vdw_p,
    localparam int c_IDW  = $clog2(reqs_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [reqs_p-1:0]         req_v_i,
    output logic [reqs_p-1:0]         req_ready_o,
    input  logic [reqs_p*4-1:0]       req_op_i,
    input  logic [reqs_p*c_VAW-1:0]   req_addr_a_i,
    input  logic [reqs_p*c_VAW-1:0]   req_addr_b_i,
    input  logic [reqs_p*c_VAW-1:0]   req_addr_c_i,
    input  logic [reqs_p*c_VAW-1:0]   req_addr_d_i,
    input  logic [reqs_p*vdw_p-1:0]   req_scalar_i,
    input  logic [reqs_p*c_DW-1:0]    req_wdata_i,
    output logic                      resp_v_o,
    output logic [c_IDW-1:0]          resp_id_o,
    output logic                      resp_err_o,
    output logic [c_DW-1:0]           resp_data_o,
    input  logic                      resp_yumi_i,
    output logic                      unit_v_o,
    input  logic                      unit_ready_i,
    output logic [3:0]                unit_op_o,
    output logic [c_VAW-1:0]          unit_addr_a_o,
    output logic [c_VAW-1:0]          unit_addr_b_o,
    output logic [c_VAW-1:0]          unit_addr_c_o,
    output logic [c_VAW-1:0]          unit_addr_d_o,
    output logic [vdw_p-1:0]          unit_scalar_o,
    output logic [c_DW-1:0]           unit_wdata_o,
    input  logic                      unit_v_i,
    input  logic [c_DW-1:0]           unit_data_i,
    output logic                      unit_yumi_o
`ifdef VEC_ISSUE_ARB_PERF_EN
    ,
    output logic [31:0]               perf_busy_o,
    output logic [reqs_p*32-1:0]      perf_grants_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [3:0] c_OP_READ = 4'b1000;

    logic [1:0]        r_state;
    logic [c_IDW-1:0]  r_rr_ptr;
    logic [c_IDW-1:0]  r_id;
    logic              r_err;
    logic [3:0]        r_op;
    logic [c_VAW-1:0]  r_addr_a, r_addr_b, r_addr_c, r_addr_d;
    logic [vdw_p-1:0]  r_scalar;
    logic [c_DW-1:0]   r_wdata;
    logic [c_DW-1:0]   r_resp_data;

    logic              w_gnt_v;
    logic [c_IDW-1:0]  w_gnt_id;
    logic              w_illegal;
    logic              w_grant;

    logic [3:0]        w_op_arr     [reqs_p];
    logic [c_VAW-1:0]  w_addr_a_arr [reqs_p];
    logic [c_VAW-1:0]  w_addr_b_arr [reqs_p];
    logic [c_VAW-1:0]  w_addr_c_arr [reqs_p];
    logic [c_VAW-1:0]  w_addr_d_arr [reqs_p];
    logic [vdw_p-1:0]  w_scalar_arr [reqs_p];
    logic [c_DW-1:0]   w_wdata_arr  [reqs_p];

    for (genvar k = 0; k < reqs_p; k++) begin : g_unpack
        assign w_op_arr[k]     = req_op_i[k*4 +: 4];
        assign w_addr_a_arr[k] = req_addr_a_i[k*c_VAW +: c_VAW];
        assign w_addr_b_arr[k] = req_addr_b_i[k*c_VAW +: c_VAW];
        assign w_addr_c_arr[k] = req_addr_c_i[k*c_VAW +: c_VAW];
        assign w_addr_d_arr[k] = req_addr_d_i[k*c_VAW +: c_VAW];
        assign w_scalar_arr[k] = req_scalar_i[k*vdw_p +: vdw_p];
        assign w_wdata_arr[k]  = req_wdata_i[k*c_DW +: c_DW];
    end

    // Lowest index above the pointer wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        w_gnt_v  = 1'b0;
        w_gnt_id = '0;
        for (int k = reqs_p - 1; k >= 0; k--) begin
            if (req_v_i[k] && (c_IDW'(k) <= r_rr_ptr)) begin
                w_gnt_v  = 1'b1;
                w_gnt_id = c_IDW'(k);
            end
        end
        for (int k = reqs_p - 1; k >= 0; k--) begin
            if (req_v_i[k] && (c_IDW'(k) > r_rr_ptr)) begin
                w_gnt_v  = 1'b1;
                w_gnt_id = c_IDW'(k);
            end
        end
    end

    assign w_illegal = (w_op_arr[w_gnt_id] == 4'b0111) || (w_op_arr[w_gnt_id] >= 4'b1010);
    assign w_grant   = (r_state == S_IDLE) && w_gnt_v;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= c_IDW'(reqs_p - 1);
            r_id        <= '0;
            r_err       <= 1'b0;
            r_op        <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_addr_c    <= '0;
            r_addr_d    <= '0;
            r_scalar    <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_v) begin
                        r_rr_ptr    <= w_gnt_id;
                        r_id        <= w_gnt_id;
                        r_err       <= w_illegal;
                        r_op        <= w_op_arr[w_gnt_id];
                        r_addr_a    <= w_addr_a_arr[w_gnt_id];
                        r_addr_b    <= w_addr_b_arr[w_gnt_id];
                        r_addr_c    <= w_addr_c_arr[w_gnt_id];
                        r_addr_d    <= w_addr_d_arr[w_gnt_id];
                        r_scalar    <= w_scalar_arr[w_gnt_id];
                        r_wdata     <= w_wdata_arr[w_gnt_id];
                        r_resp_data <= '0;
                        r_state     <= w_illegal ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (unit_ready_i) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (unit_v_i) begin
                        r_resp_data <= (r_op == c_OP_READ) ? unit_data_i : '0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_yumi_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ready is gated by reset so every output reads zero while reset is held.
    assign req_ready_o   = (reset_n_i && w_grant) ? ({{(reqs_p-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
    assign unit_v_o      = (r_state == S_ISSUE);
    assign unit_yumi_o   = (r_state == S_WAIT) && unit_v_i;
    assign resp_v_o      = (r_state == S_RESP);
    assign resp_id_o     = r_id;
    assign resp_err_o    = r_err;
    assign resp_data_o   = r_resp_data;
    assign unit_op_o     = r_op;
    assign unit_addr_a_o = r_addr_a;
    assign unit_addr_b_o = r_addr_b;
    assign unit_addr_c_o = r_addr_c;
    assign unit_addr_d_o = r_addr_d;
    assign unit_scalar_o = r_scalar;
    assign unit_wdata_o  = r_wdata;

`ifdef VEC_ISSUE_ARB_PERF_EN
    logic [31:0] r_perf_busy;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_perf_busy <= '0;
        end else if ((r_state != S_IDLE) && (r_perf_busy != '1)) begin
            r_perf_busy <= r_perf_busy + 32'd1;
        end
    end
    assign perf_busy_o = r_perf_busy;

    for (genvar k = 0; k < reqs_p; k++) begin : g_perf_grant
        logic [31:0] r_grant_cnt;
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_grant_cnt <= '0;
            end else if (w_grant && (w_gnt_id == c_IDW'(k)) && (r_grant_cnt != '1)) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
        end
        assign perf_grants_o[k*32 +: 32] = r_grant_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_issue_arbiter.sv
// ============================================================================
// Module   : tb_vec_issue_arbiter
// Purpose  : Directed and randomized self-checking bench for vec_issue_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_issue_arbiter;

    localparam int N   = 2;
    localparam int VAW = 3;
    localparam int VDW = 8;
    localparam int DW  = 64;

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b1;
    logic [N-1:0]      req_v_i;
    logic [N-1:0]      req_ready_o;
    logic [N*4-1:0]    req_op_i;
    logic [N*VAW-1:0]  req_addr_a_i, req_addr_b_i, req_addr_c_i, req_addr_d_i;
    logic [N*VDW-1:0]  req_scalar_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic              resp_v_o;
    logic [0:0]        resp_id_o;
    logic              resp_err_o;
    logic [DW-1:0]     resp_data_o;
    logic              resp_yumi_i = 1'b0;
    logic              unit_v_o;
    logic              unit_ready_i = 1'b0;
    logic [3:0]        unit_op_o;
    logic [VAW-1:0]    unit_addr_a_o, unit_addr_b_o, unit_addr_c_o, unit_addr_d_o;
    logic [VDW-1:0]    unit_scalar_o;
    logic [DW-1:0]     unit_wdata_o;
    logic              unit_v_i = 1'b0;
    logic [DW-1:0]     unit_data_i = '0;
    logic              unit_yumi_o;

    // Requester-side command table
    logic              tv  [N];
    logic [3:0]        top [N];
    logic [VAW-1:0]    ta [N], tb [N], tc [N], td [N];
    logic [VDW-1:0]    tsc [N];
    logic [DW-1:0]     twd [N];

    int m_ptr;
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_ord [3] = '{0, 1, 0};

    vec_issue_arbiter dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_a_i(req_addr_a_i), .req_addr_b_i(req_addr_b_i),
        .req_addr_c_i(req_addr_c_i), .req_addr_d_i(req_addr_d_i),
        .req_scalar_i(req_scalar_i), .req_wdata_i(req_wdata_i),
        .resp_v_o(resp_v_o), .resp_id_o(resp_id_o), .resp_err_o(resp_err_o),
        .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .unit_v_o(unit_v_o), .unit_ready_i(unit_ready_i), .unit_op_o(unit_op_o),
        .unit_addr_a_o(unit_addr_a_o), .unit_addr_b_o(unit_addr_b_o),
        .unit_addr_c_o(unit_addr_c_o), .unit_addr_d_o(unit_addr_d_o),
        .unit_scalar_o(unit_scalar_o), .unit_wdata_o(unit_wdata_o),
        .unit_v_i(unit_v_i), .unit_data_i(unit_data_i), .unit_yumi_o(unit_yumi_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_v_i[k]                 = tv[k];
            req_op_i[k*4 +: 4]         = top[k];
            req_addr_a_i[k*VAW +: VAW] = ta[k];
            req_addr_b_i[k*VAW +: VAW] = tb[k];
            req_addr_c_i[k*VAW +: VAW] = tc[k];
            req_addr_d_i[k*VAW +: VAW] = td[k];
            req_scalar_i[k*VDW +: VDW] = tsc[k];
            req_wdata_i[k*DW +: DW]    = twd[k];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [3:0] op);
        return (op == 4'd7) || (op >= 4'd10);
    endfunction

    task automatic gen_cmd(input int k);
        tv[k]  = 1'b1;
        top[k] = ($urandom % 4 == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(8, 0));
        ta[k]  = 3'($urandom);
        tb[k]  = 3'($urandom);
        tc[k]  = 3'($urandom);
        td[k]  = 3'($urandom);
        tsc[k] = 8'($urandom);
        twd[k] = {$urandom, $urandom};
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < N; k++) begin
            tv[k] = 1'b0; top[k] = '0; ta[k] = '0; tb[k] = '0;
            tc[k] = '0; td[k] = '0; tsc[k] = '0; twd[k] = '0;
        end
    endtask

    // Leaves the bench at a falling edge with the controller idle.
    task automatic do_reset();
        reset_n_i = 1'b0;
        #3;
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_unit_v", unit_v_o, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_op", unit_op_o, 0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        m_ptr = N - 1;
    endtask

    // Called at an idle-cycle falling edge with the request table already set.
    task automatic run_txn(input int rdly, input int ddly, input int ydly,
                           input logic [63:0] rdata, input bit refill, output int g);
        logic [3:0] op;
        logic [VAW-1:0] a, b, c, d;
        logic [VDW-1:0] sc;
        logic [DW-1:0] wd, exp_data;
        g = -1;
        for (int i = 1; i <= N; i++) begin
            if (g < 0 && tv[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
        #1;
        if (g < 0) begin
            chk("no_req_ready", req_ready_o, 0);
            return;
        end
        chk("grant_ready", req_ready_o, 64'(1) << g);
        op = top[g]; a = ta[g]; b = tb[g]; c = tc[g]; d = td[g]; sc = tsc[g]; wd = twd[g];
        m_ptr = g;
        @(posedge clk_i);
        @(negedge clk_i);
        if (refill) gen_cmd(g);
        else tv[g] = 1'b0;
        #1;
        chk("busy_ready", req_ready_o, 0);
        exp_data = '0;
        if (is_illegal(op)) begin
            chk("ill_resp_v", resp_v_o, 1);
            chk("ill_err", resp_err_o, 1);
            chk("ill_unit_v", unit_v_o, 0);
        end else begin
            chk("issue_v", unit_v_o, 1);
            chk("issue_op", unit_op_o, op);
            chk("issue_addr", {unit_addr_a_o, unit_addr_b_o, unit_addr_c_o, unit_addr_d_o}, {a, b, c, d});
            chk("issue_scalar", unit_scalar_o, sc);
            chk("issue_wdata", unit_wdata_o, wd);
            for (int r = 0; r < rdly; r++) begin
                @(negedge clk_i); #1;
                chk("stall_v", unit_v_o, 1);
                chk("stall_addr", {unit_op_o, unit_addr_d_o}, {op, d});
            end
            unit_ready_i = 1'b1;
            @(negedge clk_i);
            unit_ready_i = 1'b0;
            #1;
            chk("wait_v", unit_v_o, 0);
            chk("wait_yumi_idle", unit_yumi_o, 0);
            chk("wait_hold", {unit_op_o, unit_addr_a_o, unit_wdata_o}, {op, a, wd});
            for (int r = 0; r < ddly; r++) begin
                @(negedge clk_i); #1;
                chk("wait_resp_v", resp_v_o, 0);
            end
            unit_v_i = 1'b1;
            unit_data_i = rdata;
            #1;
            chk("done_yumi", unit_yumi_o, 1);
            @(negedge clk_i);
            unit_v_i = 1'b0;
            unit_data_i = {$urandom, $urandom};
            #1;
            exp_data = (op == 4'b1000) ? rdata : '0;
            chk("resp_v", resp_v_o, 1);
            chk("resp_err", resp_err_o, 0);
            chk("resp_hold_op", unit_op_o, op);
        end
        chk("resp_id", resp_id_o, g);
        chk("resp_data", resp_data_o, exp_data);
        for (int r = 0; r < ydly; r++) begin
            @(negedge clk_i);
            unit_v_i = 1'($urandom);
            #1;
            chk("hold_resp_v", resp_v_o, 1);
            chk("hold_data", resp_data_o, exp_data);
            chk("hold_ready", req_ready_o, 0);
            chk("hold_yumi", unit_yumi_o, 0);
        end
        unit_v_i = 1'b0;
        resp_yumi_i = 1'b1;
        @(negedge clk_i);
        resp_yumi_i = 1'b0;
    endtask

    initial begin
        int g;
        bit any;
        clear_reqs();
        do_reset();

        // Single add from requester 0
        tv[0] = 1'b1; top[0] = 4'b0000; ta[0] = 3'd1; tb[0] = 3'd2; tc[0] = 3'd0; td[0] = 3'd3;
        tsc[0] = 8'h5A; twd[0] = 64'h1122334455667788;
        run_txn(0, 4, 0, 64'hFFFF_0000_FFFF_0000, 1'b0, g);
        chk("t1_grant", g, 0);

        // Contention from reset: order 0,1,0
        clear_reqs();
        do_reset();
        gen_cmd(0); gen_cmd(1);
        for (int i = 0; i < 3; i++) begin
            run_txn(int'($urandom % 2), int'($urandom % 3), 0, {$urandom, $urandom}, 1'b1, g);
            chk("t2_order", g, exp_ord[i]);
        end
        clear_reqs();

        // Read op with a held response while requester 0 waits
        gen_cmd(0); gen_cmd(1); top[1] = 4'b1000;
        run_txn(0, 2, 5, 64'hDEADBEEF01234567, 1'b0, g);
        chk("t3_grant", g, 1);

        // Unit not ready for three cycles
        top[0] = 4'b0010;
        run_txn(3, 1, 0, {$urandom, $urandom}, 1'b0, g);
        chk("t5_grant", g, 0);

        // Illegal opcode from requester 1
        gen_cmd(1); top[1] = 4'b1011;
        run_txn(0, 0, 0, {$urandom, $urandom}, 1'b0, g);
        chk("t4_grant", g, 1);

        // Reset while waiting on the unit
        gen_cmd(0); top[0] = 4'b0011;
        #1;
        chk("t6_ready", req_ready_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        tv[0] = 1'b0;
        unit_ready_i = 1'b1;
        @(negedge clk_i);
        unit_ready_i = 1'b0;
        unit_v_i = 1'b1;
        gen_cmd(0); gen_cmd(1);
        #1;
        chk("t6_wait_yumi", unit_yumi_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("t6_rst_yumi", unit_yumi_o, 0);
        chk("t6_rst_op", unit_op_o, 0);
        chk("t6_rst_ready", req_ready_o, 0);
        chk("t6_rst_resp", {resp_v_o, resp_err_o, resp_id_o}, 0);
        @(negedge clk_i);
        unit_v_i = 1'b0;
        reset_n_i = 1'b1;
        m_ptr = N - 1;
        run_txn(0, 1, 0, {$urandom, $urandom}, 1'b0, g);
        chk("t6_grant", g, 0);
        clear_reqs();

        // Randomized traffic against the round-robin model
        for (int it = 0; it < 40; it++) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!tv[k] && ($urandom % 2 == 0)) gen_cmd(k);
                any = any | tv[k];
            end
            if (!any) begin
                #1;
                chk("idle_ready", req_ready_o, 0);
                @(negedge clk_i);
                gen_cmd(int'($urandom % N));
            end
            run_txn(int'($urandom % 3), int'($urandom % 4), int'($urandom % 3),
                    {$urandom, $urandom}, 1'($urandom), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vec_issue_arbiter.md
Name: vec_issue_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one vector unit between `reqs_p` requesters.
- Accepts one command per grant, latches it, and presents it to the unit. It holds opcode and register addresses stable for the whole operation, because the unit does not latch them.
- Waits for unit completion, captures read data and returns a tagged response to the granted requester.
- One operation is in flight at a time. The block sits between the command fabric and the vector unit.

Parameters:
- reqs_p, 2, number of requesters (≥2)
- els_p, 8, vectors in VRF; `vaw = clog2(els_p)`
- vlen_p, 8, elements per vector
- vdw_p, 8, bits per element; `dw = vlen_p*vdw_p`
- `idw = clog2(reqs_p)` (derived)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_v_i  in  reqs_p  command valid per requester
- req_ready_o  out  reqs_p  command accepted (one-hot or zero)
- req_op_i  in  reqs_p*4  opcode per requester
- req_addr_a_i/b_i/c_i/d_i  in  reqs_p*vaw each  operand/destination vector indices
- req_scalar_i  in  reqs_p*vdw_p  scalar operand
- req_wdata_i  in  reqs_p*dw  write data (op 1001)
- resp_v_o  out  1  response valid
- resp_id_o  out  idw  requester index of response
- resp_err_o  out  1  illegal opcode, not executed
- resp_data_o  out  dw  read data (0 unless op 1000)
- resp_yumi_i  in  1  response consumed
- unit_v_o  out  1  command valid to vector unit
- unit_ready_i  in  1  unit idle
- unit_op_o  out  4  held opcode
- unit_addr_a_o/b_o/c_o/d_o  out  vaw each  held addresses
- unit_scalar_o  out  vdw_p  held scalar
- unit_wdata_o  out  dw  held write data
- unit_v_i  in  1  unit done
- unit_data_i  in  dw  unit read data
- unit_yumi_o  out  1  done acknowledge

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; `rr_ptr=reqs_p-1`, so req 0 has top priority after reset. All outputs and held registers are 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is the first `req_v_i` found searching upward from `rr_ptr+1`, mod `reqs_p`.
  - `req_ready_o[g]=1` combinationally in the same cycle.
  - On grant: latch op, addresses, scalar, wdata and id; set `rr_ptr=g`.
  - Next state: ISSUE. If the op is illegal (0111, 1010–1111), next state is RESP with `err=1` and the unit is not touched.
  - No `req_v_i`: stay in IDLE.
- ISSUE: `unit_v_o=1`. When `unit_ready_i=1`, next state is WAIT. `unit_v_o` drops the following cycle (single-cycle handshake).
- WAIT:
  - `unit_v_o=0`; `unit_yumi_o = unit_v_i` (combinational).
  - On `unit_v_i`: capture `unit_data_i` into `resp_data` if op=1000, else 0. Next state: RESP.
- RESP: `resp_v_o=1` with `resp_id_o` and `resp_err_o`. On `resp_yumi_i`, next state is IDLE, with no bubble before the next grant decision.
- unit_* command outputs stay constant from grant until the cycle after leaving WAIT. They change only at the next grant.
- `req_ready_o` is 0 in all states except IDLE. Requesters hold `req_v_i` and fields until ready.
- Simultaneous requests: exactly one grant per IDLE cycle.
  - Requester granted last has lowest priority next.
  - A requester continuously asserting valid is never starved beyond `reqs_p-1` intervening grants.
- Latency: grant→`unit_v_o` 1 cycle; `unit_v_i`→`resp_v_o` 1 cycle; illegal op grant→`resp_v_o` 1 cycle.
- `resp_yumi_i` outside RESP is ignored. `unit_v_i` outside WAIT is ignored, and `unit_yumi_o=0` there.
- Reset mid-operation: the controller returns to IDLE immediately. It does not reset the unit; the system resets both together.

Optional Feature:
VEC_ISSUE_ARB_PERF_EN:
- Defined: adds outputs `perf_busy_o` (32b) and `perf_grants_o` (reqs_p*32b).
  - `perf_busy_o` counts cycles with state≠IDLE.
  - `perf_grants_o` has one counter per requester, incremented on each grant.
  - Counters saturate at all-ones and are cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single req0 add (op 0000, A=1, B=2, D=3) → `req_ready_o=01`; `unit_v_o` next cycle with addrs held; unit done after 4 cycles → `resp_v_o`, id=0, err=0, data=0.
- req0 and req1 both valid for 3 back-to-back ops → grant order 0,1,0. `rr_ptr` ends at 0.
- Read op 1000 with `unit_data_i=64'hDEADBEEF01234567` → `unit_yumi_o` pulses with `unit_v_i`; `resp_data_o` equals that value. Hold `resp_yumi_i=0` for 5 cycles → response stable, no new grant.
- Illegal op 1011 from req1 → `resp_v_o` one cycle after grant, err=1; `unit_v_o` never asserted.
- `unit_ready_i=0` for 3 cycles during ISSUE → `unit_v_o` held high with stable fields, then WAIT entered.
- Assert `reset_n_i=0` mid-WAIT → all outputs 0 asynchronously; after release, req0 is granted before req1 when both are valid.
